// File: rtl/mux_result_fifo_if.sv
// Handshake bundle between the multiplexor stage, the result FIFO and its consumer.
// Carries dout_par only when MUX_RESULT_PARITY_EN is defined.
interface mux_result_fifo_if;
    logic [15:0] R;
    logic        en;
    logic [2:0]  SEL;
    logic        wr_stb;
    logic [15:0] dout_data;
    logic [2:0]  dout_tag;
    logic        dout_valid;
    logic        dout_ready;
`ifdef MUX_RESULT_PARITY_EN
    logic        dout_par;
`endif

    modport slave (
        input  R, en, SEL, wr_stb, dout_ready,
`ifdef MUX_RESULT_PARITY_EN
        output dout_par,
`endif
        output dout_data, dout_tag, dout_valid
    );

    modport master (
        output R, en, SEL, wr_stb, dout_ready,
`ifdef MUX_RESULT_PARITY_EN
        input  dout_par,
`endif
        input  dout_data, dout_tag, dout_valid
    );
endinterface

// File: rtl/mux_result_fifo.sv
// Result capture FIFO behind the operation multiplexor: first-word-fall-through head,
// occupancy and sticky debug flags. Optional per-entry parity via MUX_RESULT_PARITY_EN.
module mux_result_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    mux_result_fifo_if.slave bus,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          inv_cap
);
`ifdef MUX_RESULT_PARITY_EN
    localparam int EW = 20;
`else
    localparam int EW = 19;
`endif
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;
    logic          inv_cap_reg;

    logic          push;
    logic          pop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head_entry;

    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign inv_cap  = inv_cap_reg;

    assign pop  = bus.dout_valid & bus.dout_ready;
    assign push = bus.wr_stb & bus.en & (~full | pop);

`ifdef MUX_RESULT_PARITY_EN
    assign wr_entry = {^{bus.SEL, bus.R}, bus.SEL, bus.R};
`else
    assign wr_entry = {bus.SEL, bus.R};
`endif

    // Writing into the slot being popped only happens when full, so the head never changes under a stall.
    always_ff @(posedge clk) begin
        if (rst_n && !clr && push) begin
            mem[wr_ptr_reg] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            inv_cap_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
            // An invalid capture is reported instead of, never in addition to, an overflow.
            if (bus.wr_stb && !bus.en) begin
                inv_cap_reg <= 1'b1;
            end else if (bus.wr_stb && full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign head_entry     = mem[rd_ptr_reg];
    assign bus.dout_valid = ~empty;
    assign bus.dout_data  = empty ? 16'h0000 : head_entry[15:0];
    assign bus.dout_tag   = empty ? 3'd0 : head_entry[18:16];
`ifdef MUX_RESULT_PARITY_EN
    assign bus.dout_par   = empty ? 1'b0 : head_entry[19];
`endif
endmodule

// File: tb/tb_mux_result_fifo.sv
// Directed bench for mux_result_fifo: queue scoreboard of expected {tag, data} entries,
// immediate-assertion checks, one line per transaction.
module tb_mux_result_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [3:0] count;
    logic       full, empty, overflow, inv_cap;
    int         total = 0;
    int         bad   = 0;
    logic [18:0] sb_q [$];
    logic [18:0] exp_e;
    logic [3:0]  cnt_before;

    mux_result_fifo_if bus ();

    mux_result_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .bus      (bus.slave),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .inv_cap  (inv_cap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] r, input logic [2:0] sel, input bit accept);
        bus.R = r; bus.SEL = sel; bus.en = 1'b1; bus.wr_stb = 1'b1;
        if (accept) sb_q.push_back({sel, r});
        $display("push R=%h SEL=%0d accept=%0d", r, sel, accept);
        step();
        bus.wr_stb = 1'b0;
    endtask

    // Compares the current head with the scoreboard front, then pops it.
    task automatic check_head(input string tag);
        exp_e = (sb_q.size() > 0) ? sb_q.pop_front() : 19'h0;
        chk({tag, "_valid"}, 32'(bus.dout_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.dout_data), 32'(exp_e[15:0]));
        chk({tag, "_tag"}, 32'(bus.dout_tag), 32'(exp_e[18:16]));
`ifdef MUX_RESULT_PARITY_EN
        chk({tag, "_par"}, 32'(bus.dout_par), 32'(^exp_e));
`endif
        $display("pop data=%h tag=%0d", bus.dout_data, bus.dout_tag);
    endtask

    task automatic pop_one(input string tag);
        check_head(tag);
        bus.dout_ready = 1'b1;
        step();
        bus.dout_ready = 1'b0;
    endtask

    task automatic check_empty(input string tag);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_valid0"}, 32'(bus.dout_valid), 32'd0);
        chk({tag, "_data0"}, 32'(bus.dout_data), 32'd0);
        chk({tag, "_tag0"}, 32'(bus.dout_tag), 32'd0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        sb_q.delete();
        $display("clr");
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        bus.R = 16'hAAAA; bus.SEL = 3'd5; bus.en = 1'b1; bus.wr_stb = 1'b1; bus.dout_ready = 1'b0;

        // Reset hold with capture requests present.
        step(); step();
        $display("reset hold");
        check_empty("rst");
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_inv", 32'(inv_cap), 32'd0);
        rst_n = 1'b1; bus.wr_stb = 1'b0;
        step();
        check_empty("idle");

        // Single push, held while stalled.
        push(16'h1234, 3'd2, 1'b1);
        chk("single_count", 32'(count), 32'd1);
        chk("single_valid", 32'(bus.dout_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_data", 32'(bus.dout_data), 32'h1234);
            chk("hold_tag", 32'(bus.dout_tag), 32'd2);
        end
        pop_one("single");
        check_empty("single_after");

        // Fill to full, ninth capture dropped.
        for (int i = 1; i <= 9; i++) begin
            push(16'(i), 3'(i), i <= 8);
            if (i == 8) chk("fill_full", 32'(full), 32'd1);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_inv", 32'(inv_cap), 32'd0);
        for (int i = 1; i <= 8; i++) pop_one("drain");
        check_empty("drain_done");
        chk("ovf_sticky", 32'(overflow), 32'd1);
        do_clr();
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i), 3'(i), 1'b1);
        check_head("full_pp");
        bus.R = 16'hBEEF; bus.SEL = 3'd7; bus.en = 1'b1; bus.wr_stb = 1'b1; bus.dout_ready = 1'b1;
        sb_q.push_back({3'd7, 16'hBEEF});
        step();
        bus.wr_stb = 1'b0; bus.dout_ready = 1'b0;
        chk("fullpp_count", 32'(count), 32'd8);
        chk("fullpp_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 7; i++) pop_one("fullpp_drain");
        chk("fullpp_last", 32'(bus.dout_data), 32'hBEEF);
        pop_one("fullpp_beef");
        check_empty("fullpp_done");

        // Invalid capture, then clear while a capture is requested.
        push(16'h5555, 3'd1, 1'b1);
        cnt_before = count;
        bus.R = 16'hFFFF; bus.SEL = 3'd3; bus.en = 1'b0; bus.wr_stb = 1'b1;
        $display("invalid capture R=ffff");
        step();
        bus.wr_stb = 1'b0; bus.en = 1'b1;
        chk("inv_count", 32'(count), 32'(cnt_before));
        chk("inv_set", 32'(inv_cap), 32'd1);
        chk("inv_no_ovf", 32'(overflow), 32'd0);
        chk("inv_head", 32'(bus.dout_data), 32'h5555);
        bus.wr_stb = 1'b1; bus.R = 16'h7777;
        do_clr();
        bus.wr_stb = 1'b0;
        chk("clr_inv", 32'(inv_cap), 32'd0);
        check_empty("clr");

        // Wrap-around with one entry in flight.
        push(16'h0001, 3'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check_head("wrap");
            bus.R = 16'($urandom); bus.SEL = 3'($urandom_range(0, 7));
            bus.en = 1'b1; bus.wr_stb = 1'b1; bus.dout_ready = 1'b1;
            sb_q.push_back({bus.SEL, bus.R});
            step();
            bus.wr_stb = 1'b0; bus.dout_ready = 1'b0;
            chk("wrap_count", 32'(count), 32'd1);
        end
        pop_one("wrap_last");
        check_empty("wrap_done");

`ifdef MUX_RESULT_PARITY_EN
        push(16'h0001, 3'd0, 1'b1);
        chk("par_one", 32'(bus.dout_par), 32'd1);
        pop_one("par");
        chk("par_empty", 32'(bus.dout_par), 32'd0);
`endif

        // Reset in the middle of operation discards stored entries.
        push(16'h0A0A, 3'd4, 1'b1);
        push(16'h0B0B, 3'd5, 1'b1);
        rst_n = 1'b0; bus.dout_ready = 1'b1;
        step();
        rst_n = 1'b1; bus.dout_ready = 1'b0;
        sb_q.delete();
        $display("mid-operation reset");
        check_empty("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
